timer_ntick: RTL and testbench
==============================

# timer_ntick

Parametrised tick sequencer for the life engine: it counts ticks 0..N_TICKS-1 to step the per-generation phase sequence. A programmable prescaler sets the number of clocks per tick, and a count enable freezes the sequence. The block runs in free-running or one-shot (single pass per `start`) mode. It emits registered advance and wrap strobes plus an optional generation counter, and replaces the fixed 3-bit, 8-tick timer in the top-level life controller.

## Interface
- `TICK_W`, 3, width of `tick_out`; 1..16.
- `N_TICKS`, 8, ticks per pass; 2 ≤ N_TICKS ≤ 2^TICK_W.
- `PRESCALE`, 1, clocks per tick; ≥ 1 (1 = tick every enabled clock).
- `GEN_W`, 16, width of `gen_count`.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  count enable; low freezes prescaler and tick.
- `clear`  in  1  synchronous clear, see Operation.
- `oneshot`  in  1  mode: 0 free-run, 1 one-shot.
- `start`  in  1  one-shot launch request (level sampled per cycle).
- `tick_out`  out  TICK_W  current tick index.
- `tick_stb`  out  1  one-cycle pulse: tick_out advanced this cycle.
- `wrap`  out  1  one-cycle pulse: tick_out went N_TICKS-1 → 0.
- `running`  out  1  sequencer in RUN state.
- `gen_count`  out  GEN_W  completed passes, modulo 2^GEN_W.

## Operation
- States: IDLE, RUN. The prescaler `pre` runs 0..PRESCALE-1; `tick_out` runs 0..N_TICKS-1.
- Advance condition `adv` = RUN & ena & (pre == PRESCALE-1).
  - On `adv`: pre → 0; tick_out → tick_out+1, or 0 when tick_out == N_TICKS-1.
  - RUN & ena & !adv: pre → pre+1.
  - When !ena, pre and tick_out hold.
- Free-run (oneshot=0): IDLE → RUN unconditionally on the next clock. RUN never exits except by clear/reset.
- One-shot (oneshot=1):
  - IDLE & start → RUN. start is ignored in RUN.
  - On the wrap advance, RUN → IDLE, with tick_out = 0.
- Mode change:
  - 1→0 while IDLE starts running next clock.
  - 0→1 while RUN finishes the current pass and stops at the next wrap.
- clear: highest priority after rst. Next clock: pre=0, tick_out=0, state=IDLE, gen_count=0, strobes 0. Free-run re-enters RUN one clock later.
- gen_count increments on every wrap; it rolls over 2^GEN_W-1 → 0.
- Arithmetic is unsigned. tick_out never takes values ≥ N_TICKS, even when N_TICKS < 2^TICK_W.
- start with ena low: enters RUN; counting begins when ena rises.

## Timing
- All outputs are registered. No combinational path from input to output.
- Reset values: tick_out=0, pre=0, state IDLE, running=0, tick_stb=0, wrap=0, gen_count=0.
- Reset asserts asynchronously; release is clean at the next clock edge.
- Strobe alignment:
  - tick_stb and wrap are high in the same cycle tick_out first shows its new value.
  - wrap implies tick_stb.
  - gen_count shows the incremented value in the same cycle as wrap.
- Latency, free-run with ena=1: first advance occurs PRESCALE clocks after running rises.
- One-shot pass length: N_TICKS·PRESCALE enabled clocks from the start-sampling edge to the cycle wrap is high. running falls in that same cycle.
- Reset mid-pass: outputs return to reset values immediately. No strobe is generated.

## Configuration
- `TIMER_NTICK_GEN_COUNT_EN` defined: gen_count register and incrementer are built as described.
- Not defined: no gen_count logic is built, and gen_count is tied to 0. All other behaviour is identical.

## Test plan
- Free-run, N_TICKS=8, PRESCALE=1, ena=1 after reset → tick_out 0,1,…,7,0. tick_stb high every cycle from the first advance. wrap high exactly when tick_out returns to 0. gen_count=1 after the first wrap.
- N_TICKS=5, TICK_W=3, PRESCALE=3 → each tick value held 3 clocks; sequence 0..4,0. Values 5–7 never appear. wrap every 15 clocks.
- One-shot, N_TICKS=4, PRESCALE=2: single-cycle start → running=1 next clock. wrap after 8 clocks, with running=0 and tick_out=0 in that cycle. start pulses during RUN have no effect.
- ena low for 3 clocks mid-tick (PRESCALE=4) → pre and tick_out frozen, no strobes. The tick completes 3 clocks late with no lost or duplicated tick.
- clear at tick_out=6 in free-run → next clock tick_out=0, running=0, gen_count=0. Clock after that, running=1. Reset asserted mid-pass → all outputs 0 immediately.
- GEN_W=2, macro defined: 4 wraps → gen_count 1,2,3,0. Macro undefined: gen_count stays 0.

Source files
------------

// File: rtl/timer_ntick.sv
// Tick sequencer: prescaled tick counter 0..N_TICKS-1 with free-run and one-shot modes.
// Optional generation counter built when TIMER_NTICK_GEN_COUNT_EN is defined.
module timer_ntick #(
  parameter int TICK_W   = 3,
  parameter int N_TICKS  = 8,
  parameter int PRESCALE = 1,
  parameter int GEN_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              clear,
  input  logic              oneshot,
  input  logic              start,
  output logic [TICK_W-1:0] tick_out,
  output logic              tick_stb,
  output logic              wrap,
  output logic              running,
  output logic [GEN_W-1:0]  gen_count
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(N_TICKS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [PRE_W-1:0]    r_pre, w_pre_nxt;
  logic [TICK_W-1:0]   r_tick, w_tick_nxt;
  logic                r_stb, w_stb_nxt;
  logic                r_wrap, w_wrap_nxt;
  logic                w_adv;

  assign w_adv = (r_state == RUN) && ena && (r_pre == PRE_LAST);

  // NOTE: every next-value variable is given a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_tick_nxt  = r_tick;
    w_stb_nxt   = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
      w_pre_nxt   = '0;
      w_tick_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!oneshot || start) w_state_nxt = RUN;
        end
        RUN: begin
          if (w_adv) begin
            w_pre_nxt = '0;
            w_stb_nxt = 1'b1;
            // Wrapping explicitly keeps tick_out below N_TICKS for non-power-of-two counts.
            if (r_tick == TICK_LAST) begin
              w_tick_nxt = '0;
              w_wrap_nxt = 1'b1;
              if (oneshot) w_state_nxt = IDLE;
            end else begin
              w_tick_nxt = r_tick + TICK_W'(1);
            end
          end else if (ena) begin
            w_pre_nxt = r_pre + PRE_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments and the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_tick  <= '0;
      r_stb   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_tick  <= w_tick_nxt;
      r_stb   <= w_stb_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

`ifdef TIMER_NTICK_GEN_COUNT_EN
  logic [GEN_W-1:0] r_gen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gen <= '0;
    end else if (clear) begin
      r_gen <= '0;
    end else if (w_wrap_nxt) begin
      r_gen <= r_gen + GEN_W'(1);
    end
  end

  assign gen_count = r_gen;
`else
  assign gen_count = '0;
`endif

  assign tick_out = r_tick;
  assign tick_stb = r_stb;
  assign wrap     = r_wrap;
  assign running  = (r_state == RUN);

endmodule

// File: tb/tb_timer_ntick.sv
// Self-checking bench for timer_ntick: two instances (N=5/P=3 and N=8/P=1, GEN_W=2)
// checked every cycle against a pass/enabled-clock arithmetic model plus literal expectations.
module tb_timer_ntick;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic       clear = 1'b0;
  logic       oneshot = 1'b0;
  logic       start = 1'b0;

  logic [2:0] tick_o [2];
  logic       stb_o  [2];
  logic       wrap_o [2];
  logic       run_o  [2];
  logic [1:0] gen_o  [2];

  int n_checks = 0;
  int n_fail   = 0;

  int mp [2] = '{3, 1};
  int mn [2] = '{5, 8};

  timer_ntick #(.TICK_W(3), .N_TICKS(5), .PRESCALE(3), .GEN_W(2)) u_a (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .oneshot(oneshot), .start(start),
    .tick_out(tick_o[0]), .tick_stb(stb_o[0]), .wrap(wrap_o[0]), .running(run_o[0]),
    .gen_count(gen_o[0])
  );

  timer_ntick #(.TICK_W(3), .N_TICKS(8), .PRESCALE(1), .GEN_W(2)) u_b (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .oneshot(oneshot), .start(start),
    .tick_out(tick_o[1]), .tick_stb(stb_o[1]), .wrap(wrap_o[1]), .running(run_o[1]),
    .gen_count(gen_o[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_gen(input int passes);
`ifdef TIMER_NTICK_GEN_COUNT_EN
    return passes % 4;
`else
    return 0 * passes;
`endif
  endfunction

  // Model: k counts enabled RUN clocks within the current pass; tick = floor(k/P) mod N.
  bit m_run  [2];
  int m_k    [2];
  int m_gen  [2];
  bit m_stb  [2];
  bit m_wrap [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i]  <= 1'b0;
        m_k[i]    <= 0;
        m_gen[i]  <= 0;
        m_stb[i]  <= 1'b0;
        m_wrap[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int k = m_k[i];
        automatic int g = m_gen[i];
        automatic bit r = m_run[i];
        automatic bit s = 1'b0;
        automatic bit w = 1'b0;
        if (clear) begin
          r = 1'b0; k = 0; g = 0;
        end else if (!r) begin
          if (!oneshot || start) begin
            r = 1'b1; k = 0;
          end
        end else if (ena) begin
          k = k + 1;
          if (k % mp[i] == 0) begin
            s = 1'b1;
            if ((k / mp[i]) % mn[i] == 0) begin
              w = 1'b1;
              g = g + 1;
              if (oneshot) begin
                r = 1'b0; k = 0;
              end
            end
          end
        end
        m_run[i]  <= r;
        m_k[i]    <= k;
        m_gen[i]  <= g;
        m_stb[i]  <= s;
        m_wrap[i] <= w;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic string p = (i == 0) ? "a" : "b";
      check({p, "_tick"},    int'(tick_o[i]), (m_k[i] / mp[i]) % mn[i]);
      check({p, "_stb"},     int'(stb_o[i]),  int'(m_stb[i]));
      check({p, "_wrap"},    int'(wrap_o[i]), int'(m_wrap[i]));
      check({p, "_running"}, int'(run_o[i]),  int'(m_run[i]));
      check({p, "_gen"},     int'(gen_o[i]),  exp_gen(m_gen[i]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int cnt;
    #2;
    check("rst_tick_a", int'(tick_o[0]), 0);
    check("rst_run_b",  int'(run_o[1]),  0);
    check("rst_stb_b",  int'(stb_o[1]),  0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Free-run, ena high: running rises, first advance PRESCALE clocks later.
    step(1);
    check("fr_run_a", int'(run_o[0]), 1);
    check("fr_run_b", int'(run_o[1]), 1);
    check("fr_tick_b0", int'(tick_o[1]), 0);
    step(1);
    check("fr_tick_b1", int'(tick_o[1]), 1);
    check("fr_stb_b1",  int'(stb_o[1]), 1);
    check("fr_stb_a_early", int'(stb_o[0]), 0);
    step(7);
    check("fr_wrap_b_tick", int'(tick_o[1]), 0);
    check("fr_wrap_b",      int'(wrap_o[1]), 1);
    check("fr_gen_b",       int'(gen_o[1]), exp_gen(1));
    step(7);
    check("fr_wrap_a",      int'(wrap_o[0]), 1);
    check("fr_wrap_a_tick", int'(tick_o[0]), 0);
    check("fr_tick_b7",     int'(tick_o[1]), 7);

    // Directed enable gaps, including a 3-clock freeze mid-tick.
    begin
      logic [19:0] ena_pat;
      ena_pat = 20'b1110_0011_1000_1101_1011;
      for (int i = 0; i < 20; i++) begin
        ena = ena_pat[i];
        step(1);
      end
    end
    ena = 1'b1;

    // Clear at tick 6 on the N=8 instance.
    cnt = 0;
    while (tick_o[1] != 3'd6 && cnt < 16) begin
      step(1);
      cnt++;
    end
    check("clr_reach6", int'(tick_o[1]), 6);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_tick_b", int'(tick_o[1]), 0);
    check("clr_run_b",  int'(run_o[1]), 0);
    check("clr_gen_b",  int'(gen_o[1]), 0);
    check("clr_run_a",  int'(run_o[0]), 0);
    step(1);
    check("clr_rerun_b", int'(run_o[1]), 1);
    step(20);

    // Switch to one-shot while running: both finish their pass and stop.
    oneshot = 1'b1;
    cnt = 0;
    while ((run_o[0] || run_o[1]) && cnt < 100) begin
      step(1);
      cnt++;
    end
    check("os_stopped", int'(run_o[0] | run_o[1]), 0);
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("os_run_a", int'(run_o[0]), 1);
    check("os_run_b", int'(run_o[1]), 1);
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    check("os_wrap_b",   int'(wrap_o[1]), 1);
    check("os_end_run_b", int'(run_o[1]), 0);
    check("os_end_tick_b", int'(tick_o[1]), 0);
    check("os_still_a",  int'(run_o[0]), 1);
    step(7);
    check("os_wrap_a",    int'(wrap_o[0]), 1);
    check("os_end_run_a", int'(run_o[0]), 0);
    step(2);

    // Back to free-run while idle: running next clock.
    oneshot = 1'b0;
    step(1);
    check("mode_run_a", int'(run_o[0]), 1);
    check("mode_run_b", int'(run_o[1]), 1);
    step(10);

    // Asynchronous reset mid-pass.
    rst = 1'b0;
    #1;
    check("arst_tick_b", int'(tick_o[1]), 0);
    check("arst_run_a",  int'(run_o[0]), 0);
    check("arst_stb_b",  int'(stb_o[1]), 0);
    check("arst_gen_b",  int'(gen_o[1]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
